wb_mem_arbiter: RTL



---
 rtl/wb_mem_arb_pkg.sv | 15 +
 rtl/wb_mem_arbiter_if.sv | 56 +++++
 rtl/wb_mem_arbiter_rr_prio_sel.sv | 37 +++
 rtl/wb_mem_arbiter.sv | 117 +++++++++++
 4 files changed

// File: rtl/wb_mem_arb_pkg.sv
// Shared types and constants for the Wishbone main-memory arbiter.
package wb_mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// Bundle of master-side and slave-side Wishbone B3 signals around the memory arbiter.
// Signal suffixes (_i/_o) are from the arbiter's point of view.
interface wb_mem_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  localparam int SW = DW / 8;

  logic [NUM_MASTERS*AW-1:0] m_adr_i;
  logic [NUM_MASTERS*DW-1:0] m_dat_i;
  logic [NUM_MASTERS*SW-1:0] m_sel_i;
  logic [NUM_MASTERS-1:0]    m_we_i;
  logic [NUM_MASTERS-1:0]    m_cyc_i;
  logic [NUM_MASTERS-1:0]    m_stb_i;
  logic [NUM_MASTERS*3-1:0]  m_cti_i;
  logic [NUM_MASTERS*2-1:0]  m_bte_i;
  logic [DW-1:0]             m_dat_o;
  logic [NUM_MASTERS-1:0]    m_ack_o;
  logic [NUM_MASTERS-1:0]    m_err_o;
  logic [NUM_MASTERS-1:0]    m_rty_o;

  logic [AW-1:0]             s_adr_o;
  logic [DW-1:0]             s_dat_o;
  logic [SW-1:0]             s_sel_o;
  logic                      s_we_o;
  logic                      s_cyc_o;
  logic                      s_stb_o;
  logic [2:0]                s_cti_o;
  logic [1:0]                s_bte_o;
  logic [DW-1:0]             s_dat_i;
  logic                      s_ack_i;
  logic                      s_err_i;
  logic                      s_rty_i;

  logic [NUM_MASTERS-1:0]    grant_o;

  // Arbiter side.
  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
    output grant_o
  );

  // Environment side: the requesting masters plus the memory slave.
  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
    input  grant_o
  );

endinterface

// File: rtl/wb_mem_arbiter_rr_prio_sel.sv
// rr_prio_sel: combinational round-robin pick of the first set req bit at or above prio (wrapping).
// Returns one-hot grant, its index and a valid flag; no state, no latency.
module rr_prio_sel #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] prio,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [N-1:0]  rot;
  logic [PW-1:0] off;
  logic [PW:0]   sum;

  always_comb begin
    rot     = N'({req, req} >> prio);
    off     = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_vld && rot[i]) begin
        gnt_vld = 1'b1;
        off     = PW'(i);
      end
    end
    // Undo the rotation: absolute index = (prio + offset) mod N.
    sum = {1'b0, prio} + {1'b0, off};
    if (sum >= (PW+1)'(N)) begin
      sum = sum - (PW+1)'(N);
    end
    gnt_idx = sum[PW-1:0];
    gnt     = gnt_vld ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: round-robin Wishbone B3 arbiter that grants whole CYC cycles; grant 1 cycle, terminations 0 cycles.
// Build with WB_MEM_ARB_WATCHDOG_EN to error-terminate strobes the slave leaves unanswered for TIMEOUT cycles.
module wb_mem_arbiter
  import wb_mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  wb_mem_arbiter_if.slave bus
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = DW / 8;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("wb_mem_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT at least 1");
  end

  arb_state_e             state_q, state_d;
  logic [PW-1:0]          owner_q, owner_d, prio_q, prio_d, sel_idx;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, sel_gnt;
  logic                   sel_vld, owned, owner_cyc, owner_stb, active, wd_hit;

  rr_prio_sel #(.N(NUM_MASTERS), .PW(PW)) u_rr_prio_sel (
    .req     (bus.m_cyc_i),
    .prio    (prio_q),
    .gnt     (sel_gnt),
    .gnt_idx (sel_idx),
    .gnt_vld (sel_vld)
  );

  assign owned     = (state_q == OWNED);
  assign owner_cyc = bus.m_cyc_i[owner_q];
  assign owner_stb = bus.m_stb_i[owner_q];
  // Reset in the gate so a mid-cycle reset drops CYC without waiting for a clock.
  assign active    = owned & owner_cyc & ~wb_rst_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      prio_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d = OWNED;
          owner_d = sel_idx;
          grant_d = sel_gnt;
        end
      end
      OWNED: begin
        // Ownership ends only when the owner drops CYC, so bursts are never split.
        if (!owner_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          prio_d  = (owner_q == PW'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
        end
      end
    endcase
  end

`ifdef WB_MEM_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt_q;
  logic          term;

  assign term   = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
  assign wd_hit = active & (wd_cnt_q == CW'(TIMEOUT));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wd_cnt_q <= '0;
    end else if (!active || wd_hit || term) begin
      wd_cnt_q <= '0;
    end else if (owner_stb) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  assign bus.s_cyc_o = active;
  assign bus.s_stb_o = active & owner_stb & ~wd_hit;
  assign bus.s_we_o  = owned & bus.m_we_i[owner_q];
  assign bus.s_adr_o = owned ? bus.m_adr_i[owner_q*AW +: AW] : '0;
  assign bus.s_dat_o = owned ? bus.m_dat_i[owner_q*DW +: DW] : '0;
  assign bus.s_sel_o = owned ? bus.m_sel_i[owner_q*SW +: SW] : '0;
  assign bus.s_cti_o = owned ? bus.m_cti_i[owner_q*3 +: 3] : '0;
  assign bus.s_bte_o = owned ? bus.m_bte_i[owner_q*2 +: 2] : '0;

  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.m_ack_o = grant_q & {NUM_MASTERS{active & bus.s_ack_i}};
  assign bus.m_err_o = grant_q & {NUM_MASTERS{active & (bus.s_err_i | wd_hit)}};
  assign bus.m_rty_o = grant_q & {NUM_MASTERS{active & bus.s_rty_i}};
  assign bus.grant_o = grant_q;

endmodule
